// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes the A/B channels, waits for the
// synchronizers to settle after reset, then turns every legal Gray-code
// transition into a one-cycle step pulse with a direction bit and keeps
// a wrapping position count. A jump of both channels at once sets a
// sticky error flag.
module quad_decoder #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_in,
  input  logic            b_in,
  input  logic            clr,
  output logic            step,
  output logic            dir,
  output logic            err,
  output logic [BITS-1:0] Q
);

  typedef enum logic [1:0] {WAIT, LOAD, RUN} state_t;
  typedef enum logic [1:0] {MOVE_NONE, MOVE_UP, MOVE_DOWN, MOVE_BAD} move_t;

  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

  state_t          state, state_next;
  logic            wait_cnt, wait_cnt_next;
  logic            a_meta, a_s, b_meta, b_s;
  logic [1:0]      prev, prev_next, cur;
  move_t           move;
  logic            step_next, dir_next, err_next;
  logic [BITS-1:0] q_next;

  assign cur = {a_s, b_s};

  // Two-flop synchronizers bring the asynchronous channels into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_meta <= 1'b0;
      a_s    <= 1'b0;
      b_meta <= 1'b0;
      b_s    <= 1'b0;
    end else begin
      a_meta <= a_in;
      a_s    <= a_meta;
      b_meta <= b_in;
      b_s    <= b_meta;
    end
  end

  // Classify the move from the previous sample to the current one on the
  // Gray ring 00 -> 10 -> 11 -> 01 -> 00 (forward is up).
  always_comb begin
    move = MOVE_NONE;
    if (prev == cur) begin
      move = MOVE_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      move = MOVE_BAD;
    end else begin
      case ({prev, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move = MOVE_UP;
        default:                                move = MOVE_DOWN;
      endcase
    end
  end

  // Next-state and next-output logic; clr overrides Q/err in every state.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    prev_next     = prev;
    step_next     = 1'b0;
    dir_next      = dir;
    err_next      = err;
    q_next        = Q;
    case (state)
      WAIT: begin
        wait_cnt_next = 1'b1;
        if (wait_cnt) begin
          wait_cnt_next = 1'b0;
          state_next    = LOAD;
        end
      end
      LOAD: begin
        prev_next  = cur;
        state_next = RUN;
      end
      RUN: begin
        prev_next = cur;
        case (move)
          MOVE_UP: begin
            step_next = 1'b1;
            dir_next  = 1'b1;
            q_next    = Q + ONE;
          end
          MOVE_DOWN: begin
            step_next = 1'b1;
            dir_next  = 1'b0;
            q_next    = Q - ONE;
          end
          MOVE_BAD: begin
            err_next = 1'b1;
          end
          default: begin
            step_next = 1'b0;
          end
        endcase
      end
      default: begin
        state_next = WAIT;
      end
    endcase
    if (clr) begin
      q_next   = '0;
      err_next = 1'b0;
    end
  end

  // State, previous sample and all outputs are registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT;
      wait_cnt <= 1'b0;
      prev     <= 2'b00;
      step     <= 1'b0;
      dir      <= 1'b1;
      err      <= 1'b0;
      Q        <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      prev     <= prev_next;
      step     <= step_next;
      dir      <= dir_next;
      err      <= err_next;
      Q        <= q_next;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: scenario tasks plus randomized traffic,
// compared against a position-on-a-ring model of the encoder.
module tb_quad_decoder;

  localparam int BITS = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            a_in = 1'b0;
  logic            b_in = 1'b0;
  logic            clr = 1'b0;
  logic            step, dir, err;
  logic [BITS-1:0] Q;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic            mStep, mDir, mErr;
  logic [BITS-1:0] mQ;
  logic [1:0]      hist [4];
  int              edgeCnt;
  logic [1:0]      curAb;

  always #5 clk = ~clk;

  quad_decoder #(.BITS(BITS)) dut (
    .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in), .clr(clr),
    .step(step), .dir(dir), .err(err), .Q(Q)
  );

  // Position of an {A,B} level on the encoder ring (up = +1).
  function automatic int ring_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ring_ab(input int p);
    case (((p % 4) + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, return 1 time unit later for sampling.
  task automatic cycle(input logic [1:0] ab, input logic c);
    int d;
    @(negedge clk);
    {a_in, b_in} = ab;
    clr = c;
    curAb = ab;
    @(posedge clk);
    if (reset_n) begin
      edgeCnt++;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = ab;
      mStep = 1'b0;
      if (edgeCnt >= 4) begin
        d = (ring_pos(hist[2]) - ring_pos(hist[3]) + 4) % 4;
        if (d == 1) begin
          mStep = 1'b1; mDir = 1'b1; mQ = mQ + 1'b1;
        end else if (d == 3) begin
          mStep = 1'b1; mDir = 1'b0; mQ = mQ - 1'b1;
        end else if (d == 2) begin
          mErr = 1'b1;
        end
      end
      if (c) begin
        mQ = '0;
        mErr = 1'b0;
      end
    end
    #1;
  endtask

  task automatic assert_reset(input logic [1:0] ab);
    reset_n = 1'b0;
    {a_in, b_in} = ab;
    clr = 1'b0;
    curAb = ab;
    mStep = 1'b0; mDir = 1'b1; mErr = 1'b0; mQ = '0;
    edgeCnt = 0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    assert_reset(2'b11);
    checks++;
    if ({step, dir, err, Q} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got step=%b dir=%b err=%b Q=%0d, want 0/1/0/0", step, dir, err, Q);
    end
    release_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(2'b11, 1'b0);
      checks++;
      if ({step, err, Q} !== {1'b0, 1'b0, 4'd0} || {step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
        errors++;
        $display("[TB] FAIL release_11 cyc%0d: got step=%b dir=%b err=%b Q=%0d, want 0/%b/0/0", i, step, dir, err, Q, mDir);
      end
    end
  endtask

  task automatic test_up_sequence();
    int pulses = 0;
    int pulseAt;
    assert_reset(2'b00);
    release_reset();
    for (int i = 0; i < 4; i++) cycle(2'b00, 1'b0);
    for (int t = 0; t < 16; t++) begin
      pulseAt = -1;
      for (int j = 0; j < 8; j++) begin
        cycle((j == 0) ? ring_ab(ring_pos(curAb) + 1) : curAb, 1'b0);
        if (step) begin pulses++; pulseAt = j; end
        checks++;
        if ({step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
          errors++;
          $display("[TB] FAIL up_seq t%0d j%0d: got step=%b dir=%b err=%b Q=%0d, want %b/%b/%b/%0d", t, j, step, dir, err, Q, mStep, mDir, mErr, mQ);
        end
      end
      checks++;
      if (pulseAt != 2) begin
        errors++;
        $display("[TB] FAIL up_latency t%0d: step seen at offset %0d, want 2", t, pulseAt);
      end
    end
    checks++;
    if (pulses != 16 || Q !== 4'd0) begin
      errors++;
      $display("[TB] FAIL up_total: got pulses=%0d Q=%0d, want 16/0", pulses, Q);
    end
  endtask

  task automatic test_down_wrap();
    for (int j = 0; j < 6; j++) begin
      cycle((j == 0) ? 2'b01 : curAb, 1'b0);
      checks++;
      if ({step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
        errors++;
        $display("[TB] FAIL down_wrap j%0d: got step=%b dir=%b err=%b Q=%0d, want %b/%b/%b/%0d", j, step, dir, err, Q, mStep, mDir, mErr, mQ);
      end
      if (j == 2) begin
        checks++;
        if ({step, dir, Q} !== {1'b1, 1'b0, 4'd15}) begin
          errors++;
          $display("[TB] FAIL down_pulse: got step=%b dir=%b Q=%0d, want 1/0/15", step, dir, Q);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int seq [5] = '{1, 2, 1, 1, 1};
    for (int s = 0; s < 5; s++) begin
      for (int j = 0; j < 4; j++) begin
        cycle((j == 0) ? ring_ab(ring_pos(curAb) + seq[s]) : curAb, 1'b0);
        checks++;
        if ({step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
          errors++;
          $display("[TB] FAIL illegal s%0d j%0d: got step=%b dir=%b err=%b Q=%0d, want %b/%b/%b/%0d", s, j, step, dir, err, Q, mStep, mDir, mErr, mQ);
        end
      end
      if (s == 1) begin
        checks++;
        if ({step, err, Q} !== {1'b0, 1'b1, 4'd0}) begin
          errors++;
          $display("[TB] FAIL illegal_flag: got step=%b err=%b Q=%0d, want 0/1/0", step, err, Q);
        end
      end
    end
    checks++;
    if ({err, Q} !== {1'b1, 4'd3}) begin
      errors++;
      $display("[TB] FAIL err_sticky: got err=%b Q=%0d, want 1/3", err, Q);
    end
    cycle(curAb, 1'b1);
    checks++;
    if ({err, Q} !== {1'b0, 4'd0} || {err, Q} !== {mErr, mQ}) begin
      errors++;
      $display("[TB] FAIL clr_pulse: got err=%b Q=%0d, want 0/0", err, Q);
    end
  endtask

  task automatic test_clr_same_cycle();
    for (int s = 0; s < 5; s++) begin
      for (int j = 0; j < 4; j++) begin
        cycle((j == 0) ? ring_ab(ring_pos(curAb) + 1) : curAb, 1'b0);
        checks++;
        if ({step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
          errors++;
          $display("[TB] FAIL clr_setup s%0d j%0d: got step=%b dir=%b err=%b Q=%0d, want %b/%b/%b/%0d", s, j, step, dir, err, Q, mStep, mDir, mErr, mQ);
        end
      end
    end
    checks++;
    if (Q !== 4'd5) begin
      errors++;
      $display("[TB] FAIL clr_preload: got Q=%0d, want 5", Q);
    end
    cycle(ring_ab(ring_pos(curAb) + 1), 1'b0);
    cycle(curAb, 1'b0);
    cycle(curAb, 1'b1);
    checks++;
    if ({step, dir, Q} !== {1'b1, 1'b1, 4'd0} || {step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
      errors++;
      $display("[TB] FAIL clr_with_step: got step=%b dir=%b Q=%0d, want 1/1/0", step, dir, Q);
    end
    cycle(curAb, 1'b0);
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    for (int s = 0; s < 10; s++) begin
      for (int j = 0; j < ((s == 9) ? 3 : 4); j++) begin
        cycle((j == 0) ? ring_ab(ring_pos(curAb) + ((s == 0) ? 2 : 1)) : curAb, 1'b0);
        checks++;
        if ({step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
          errors++;
          $display("[TB] FAIL mid_setup s%0d j%0d: got step=%b dir=%b err=%b Q=%0d, want %b/%b/%b/%0d", s, j, step, dir, err, Q, mStep, mDir, mErr, mQ);
        end
      end
    end
    checks++;
    if ({step, err, Q} !== {1'b1, 1'b1, 4'd9}) begin
      errors++;
      $display("[TB] FAIL mid_preload: got step=%b err=%b Q=%0d, want 1/1/9", step, err, Q);
    end
    #2;
    assert_reset(curAb);
    checks++;
    if ({step, err, Q} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got step=%b err=%b Q=%0d, want 0/0/0", step, err, Q);
    end
    release_reset();
    for (int j = 0; j < 8; j++) begin
      cycle((j == 3) ? ring_ab(ring_pos(curAb) + 1) : curAb, 1'b0);
      if (step) pulses++;
      checks++;
      if ({step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
        errors++;
        $display("[TB] FAIL restart j%0d: got step=%b dir=%b err=%b Q=%0d, want %b/%b/%b/%0d", j, step, dir, err, Q, mStep, mDir, mErr, mQ);
      end
    end
    checks++;
    if (pulses != 1 || Q !== 4'd1) begin
      errors++;
      $display("[TB] FAIL restart_count: got pulses=%0d Q=%0d, want 1/1", pulses, Q);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int j = 0; j < 12; j++) begin
      cycle((j < 8) ? ring_ab(ring_pos(curAb) - 1) : curAb, 1'b0);
      if (step) pulses++;
      checks++;
      if ({step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
        errors++;
        $display("[TB] FAIL back_to_back j%0d: got step=%b dir=%b err=%b Q=%0d, want %b/%b/%b/%0d", j, step, dir, err, Q, mStep, mDir, mErr, mQ);
      end
    end
    checks++;
    if (pulses != 8) begin
      errors++;
      $display("[TB] FAIL back_to_back_count: got pulses=%0d, want 8", pulses);
    end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] nxt;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r < 8)       nxt = curAb;
      else if (r < 13) nxt = ring_ab(ring_pos(curAb) + 1);
      else if (r < 18) nxt = ring_ab(ring_pos(curAb) - 1);
      else             nxt = ring_ab(ring_pos(curAb) + 2);
      cycle(nxt, ($urandom_range(0, 15) == 0));
      checks++;
      if ({step, dir, err, Q} !== {mStep, mDir, mErr, mQ}) begin
        errors++;
        $display("[TB] FAIL random i%0d: got step=%b dir=%b err=%b Q=%0d, want %b/%b/%b/%0d", i, step, dir, err, Q, mStep, mDir, mErr, mQ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_sequence();
    test_down_wrap();
    test_illegal();
    test_clr_same_cycle();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
